// File: rtl/lsu_wb_if.sv
// lsu_wb_if: single-outstanding request/grant/response data-memory bus
interface lsu_wb_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   modport master (output req, we, addr, wstrb, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wstrb, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_wb.sv
// lsu_wb: multi-cycle load/store unit from execute to the register file write port
module lsu_wb #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        I_valid,
   output logic        O_ready,
   input  logic        I_is_store,
   input  logic [2:0]  I_funct3,
   input  logic [31:0] I_addr,
   input  logic [31:0] I_wdata,
   input  logic [4:0]  I_rd_waddr,
   lsu_wb_if.master    mem,
   output logic        O_rd_we,
   output logic [4:0]  O_rd_waddr,
   output logic [31:0] O_rd_wdata,
   output logic        O_done,
   output logic        O_exc,
   output logic [1:0]  O_exc_cause
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;
   state_t           state_q, state_d;
   logic             store_q, store_d, req_q, req_d, we_q, we_d;
   logic             rd_we_q, rd_we_d, done_q, done_d, exc_q, exc_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       off_q, off_d, cause_q, cause_d;
   logic [4:0]       rd_q, rd_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal, misal, tmo;
   logic [3:0]       strb;
   logic [31:0]      lane, ext;
   logic [7:0]       ld_b;
   logic [15:0]      ld_h;
   assign illegal = I_is_store ? I_funct3 > 3'b010 : (I_funct3 == 3'b011 || I_funct3[2:1] == 2'b11);
   assign misal   = (I_funct3[1:0] == 2'b01 && I_addr[0]) || (I_funct3[1:0] == 2'b10 && I_addr[1:0] != 2'b00);
   assign strb    = I_funct3[1:0] == 2'b00 ? 4'b0001 << I_addr[1:0] :
                    I_funct3[1:0] == 2'b01 ? 4'b0011 << I_addr[1:0] : 4'b1111;
   assign lane    = I_funct3[1:0] == 2'b00 ? {4{I_wdata[7:0]}} :
                    I_funct3[1:0] == 2'b01 ? {2{I_wdata[15:0]}} : I_wdata;
   assign ld_b    = mem.rdata[{off_q, 3'b000} +: 8];
   assign ld_h    = off_q[1] ? mem.rdata[31:16] : mem.rdata[15:0];
   assign ext     = f3_q[1] ? mem.rdata :
                    f3_q[0] ? {{16{~f3_q[2] & ld_h[15]}}, ld_h} : {{24{~f3_q[2] & ld_b[7]}}, ld_b};
   // >= so a load granted on the last REQ cycle still aborts if rvalid never comes
   assign tmo     = cnt_q >= CNT_W'(TIMEOUT - 1);
   always_comb begin
      state_d = state_q;
      store_d = store_q;
      req_d   = req_q;
      we_d    = we_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      rd_we_d = 1'b0;
      done_d  = 1'b0;
      exc_d   = 1'b0;
      cause_d = 2'b00;
      unique case (state_q)
         IDLE: if (I_valid) begin
            if (illegal || misal) begin
               exc_d   = 1'b1;
               cause_d = illegal ? 2'b10 : 2'b01;
            end else begin
               state_d = REQ;
               store_d = I_is_store;
               req_d   = 1'b1;
               we_d    = I_is_store;
               f3_d    = I_funct3;
               off_d   = I_addr[1:0];
               rd_d    = I_rd_waddr;
               addr_d  = {I_addr[31:2], 2'b00};
               wstrb_d = I_is_store ? strb : 4'b0000;
               wdata_d = lane;
               cnt_d   = '0;
            end
         end
         REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (mem.gnt) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = store_q ? IDLE : WAIT;
               done_d  = store_q;
            end else if (tmo) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = IDLE;
               exc_d   = 1'b1;
               cause_d = 2'b11;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (mem.rvalid) begin
               data_d  = ext;
               state_d = WB;
               rd_we_d = rd_q != 5'd0;
               done_d  = 1'b1;
            end else if (tmo) begin
               state_d = IDLE;
               exc_d   = 1'b1;
               cause_d = 2'b11;
            end
         end
         WB: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         store_q <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         rd_q    <= 5'd0;
         addr_q  <= 32'd0;
         wstrb_q <= 4'b0000;
         wdata_q <= 32'd0;
         data_q  <= 32'd0;
         cnt_q   <= '0;
         rd_we_q <= 1'b0;
         done_q  <= 1'b0;
         exc_q   <= 1'b0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         store_q <= store_d;
         req_q   <= req_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         rd_we_q <= rd_we_d;
         done_q  <= done_d;
         exc_q   <= exc_d;
         cause_q <= cause_d;
      end
   end
   assign O_ready     = state_q == IDLE;
   assign mem.req     = req_q;
   assign mem.we      = we_q;
   assign mem.addr    = addr_q;
   assign mem.wstrb   = wstrb_q;
   assign mem.wdata   = wdata_q;
   assign O_rd_we     = rd_we_q;
   assign O_rd_waddr  = rd_q;
   assign O_rd_wdata  = data_q;
   assign O_done      = done_q;
   assign O_exc       = exc_q;
   assign O_exc_cause = cause_q;
endmodule
